// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of a clk-synchronous strobe, compares each
// period against an expected value, and declares lock after a run of consecutive matches.
module pulse_period_meter #(
    parameter int W      = 8,
    parameter int LOCK_N = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en,
    input  logic         clr,
    input  logic         pin,
    input  logic [W-1:0] exp,
    output logic [W-1:0] period,
    output logic         per_vld,
    output logic         match,
    output logic         locked,
    output logic         ovf
);

    localparam logic [0:0]   S_IDLE   = 1'b0;
    localparam logic [0:0]   S_MEAS   = 1'b1;
    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0] CNT_ONE  = W'(1);
    localparam logic [3:0]   LOCK_TGT = 4'(LOCK_N);

    logic         r_pin_d;
    logic [0:0]   r_state;
    logic [W-1:0] r_cnt;
    logic [3:0]   r_lock_cnt;
    logic [W-1:0] r_period;
    logic         r_per_vld;
    logic         r_match;
    logic         r_locked;
    logic         r_ovf;

    logic [0:0]   w_state_nxt;
    logic [W-1:0] w_cnt_nxt;
    logic [3:0]   w_lock_cnt_nxt;
    logic [W-1:0] w_period_nxt;
    logic         w_per_vld_nxt;
    logic         w_match_nxt;
    logic         w_locked_nxt;
    logic         w_ovf_nxt;

    logic         w_edge;
    logic         w_hit;
    logic [3:0]   w_lock_inc;

    // A level held high yields exactly one edge; pin_d tracks pin even while disabled.
    assign w_edge = pin & ~r_pin_d;

    // exp = 0 can never be a valid period, so it is excluded from matching explicitly.
    assign w_hit = (r_cnt == exp) && (exp != '0);

    assign w_lock_inc = (r_lock_cnt >= LOCK_TGT) ? LOCK_TGT : r_lock_cnt + 4'd1;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_lock_cnt_nxt = r_lock_cnt;
        w_period_nxt   = r_period;
        w_per_vld_nxt  = 1'b0;
        w_match_nxt    = r_match;
        w_locked_nxt   = r_locked;
        w_ovf_nxt      = r_ovf;

        if (clr) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = '0;
            w_lock_cnt_nxt = '0;
            w_period_nxt   = '0;
            w_match_nxt    = 1'b0;
            w_locked_nxt   = 1'b0;
            w_ovf_nxt      = 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (w_edge) begin
                        w_period_nxt  = r_cnt;
                        w_per_vld_nxt = 1'b1;
                        w_match_nxt   = w_hit;
                        w_cnt_nxt     = CNT_ONE;
                        if (w_hit) begin
                            w_lock_cnt_nxt = w_lock_inc;
                            w_locked_nxt   = (w_lock_inc == LOCK_TGT);
                        end else begin
                            w_lock_cnt_nxt = '0;
                            w_locked_nxt   = 1'b0;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        // Counter is pinned at full scale: the interval is longer than measurable.
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pin_d <= 1'b0;
        end else begin
            r_pin_d <= pin;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lock_cnt <= '0;
            r_period   <= '0;
            r_per_vld  <= 1'b0;
            r_match    <= 1'b0;
            r_locked   <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_period   <= w_period_nxt;
            r_per_vld  <= w_per_vld_nxt;
            r_match    <= w_match_nxt;
            r_locked   <= w_locked_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign period  = r_period;
    assign per_vld = r_per_vld;
    assign match   = r_match;
    assign locked  = r_locked;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a W=8 and a W=4 instance share all stimulus
// except the expected-period bus; each scenario task checks its own outputs inline.
module tb_pulse_period_meter;

    logic       clk;
    logic       rst_b;
    logic       en;
    logic       clr;
    logic       pin;
    logic [7:0] exp8;
    logic [3:0] exp4;

    logic [7:0] period8;
    logic       per_vld8, match8, locked8, ovf8;
    logic [3:0] period4;
    logic       per_vld4, match4, locked4, ovf4;

    int checks;
    int failures;

    pulse_period_meter #(.W(8), .LOCK_N(4)) u_dut8 (
        .clk     (clk),
        .rst_b   (rst_b),
        .en      (en),
        .clr     (clr),
        .pin     (pin),
        .exp     (exp8),
        .period  (period8),
        .per_vld (per_vld8),
        .match   (match8),
        .locked  (locked8),
        .ovf     (ovf8)
    );

    pulse_period_meter #(.W(4), .LOCK_N(4)) u_dut4 (
        .clk     (clk),
        .rst_b   (rst_b),
        .en      (en),
        .clr     (clr),
        .pin     (pin),
        .exp     (exp4),
        .period  (period4),
        .per_vld (per_vld4),
        .match   (match4),
        .locked  (locked4),
        .ovf     (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pin = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle pulse; on return the outputs reflect the edge just sampled.
    task automatic send_edge();
        pin = 1'b1;
        step();
        pin = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        pin   = 1'b0;
        exp8  = 8'd6;
        exp4  = 4'd6;
        #12;
        checks++;
        if ({period8, per_vld8, match8, locked8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL reset_w8 got per=%0d vld=%b m=%b l=%b o=%b want all 0",
                     period8, per_vld8, match8, locked8, ovf8);
        end
        checks++;
        if ({period4, per_vld4, match4, locked4, ovf4} !== 8'h00) begin
            failures++;
            $display("FAIL reset_w4 got per=%0d vld=%b m=%b l=%b o=%b want all 0",
                     period4, per_vld4, match4, locked4, ovf4);
        end
        #3 rst_b = 1'b1;
        step();
    endtask

    task automatic test_lock();
        send_edge();
        checks++;
        if (per_vld8 !== 1'b0) begin
            failures++;
            $display("FAIL lock_arm got vld=%b want 0", per_vld8);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            checks++;
            if (per_vld8 !== 1'b0) begin
                failures++;
                $display("FAIL lock_vld_pulse%0d got vld=%b want 0", i, per_vld8);
            end
            idle(4);
            send_edge();
            checks++;
            if ({per_vld8, period8, match8, locked8} !== {1'b1, 8'd6, 1'b1, (i == 4)}) begin
                failures++;
                $display("FAIL lock_meas%0d got vld=%b per=%0d m=%b l=%b want vld=1 per=6 m=1 l=%b",
                         i, per_vld8, period8, match8, locked8, (i == 4));
            end
        end
    endtask

    task automatic test_unlock();
        idle(4);
        send_edge();
        checks++;
        if ({per_vld8, period8, match8, locked8} !== {1'b1, 8'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL unlock_short got vld=%b per=%0d m=%b l=%b want vld=1 per=5 m=0 l=0",
                     per_vld8, period8, match8, locked8);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(5);
            send_edge();
            checks++;
            if ({period8, match8, locked8} !== {8'd6, 1'b1, (i == 4)}) begin
                failures++;
                $display("FAIL relock%0d got per=%0d m=%b l=%b want per=6 m=1 l=%b",
                         i, period8, match8, locked8, (i == 4));
            end
        end
    endtask

    task automatic test_clr();
        idle(2);
        do_clr();
        checks++;
        if ({period8, per_vld8, match8, locked8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL clr_outputs got per=%0d vld=%b m=%b l=%b o=%b want all 0",
                     period8, per_vld8, match8, locked8, ovf8);
        end
        send_edge();
        checks++;
        if ({per_vld8, period8} !== {1'b0, 8'd0}) begin
            failures++;
            $display("FAIL clr_arm got vld=%b per=%0d want vld=0 per=0", per_vld8, period8);
        end
        idle(5);
        send_edge();
        checks++;
        if ({per_vld8, period8, match8} !== {1'b1, 8'd6, 1'b1}) begin
            failures++;
            $display("FAIL clr_first_meas got vld=%b per=%0d m=%b want vld=1 per=6 m=1",
                     per_vld8, period8, match8);
        end
    endtask

    task automatic test_ovf();
        do_clr();
        send_edge();
        idle(19);
        send_edge();
        checks++;
        if ({per_vld4, period4, match4, ovf4} !== {1'b1, 4'd15, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_w4 got vld=%b per=%0d m=%b o=%b want vld=1 per=15 m=0 o=1",
                     per_vld4, period4, match4, ovf4);
        end
        checks++;
        if ({period8, match8, ovf8} !== {8'd20, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ovf_w8 got per=%0d m=%b o=%b want per=20 m=0 o=0",
                     period8, match8, ovf8);
        end
        idle(5);
        send_edge();
        checks++;
        if ({period4, match4, ovf4} !== {4'd6, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL ovf_sticky got per=%0d m=%b o=%b want per=6 m=1 o=1",
                     period4, match4, ovf4);
        end
    endtask

    task automatic test_enable();
        int vld_seen;
        do_clr();
        send_edge();
        idle(2);
        vld_seen = 0;
        en  = 1'b0;
        pin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (per_vld8 !== 1'b0) vld_seen++;
        end
        en = 1'b1;
        step();
        if (per_vld8 !== 1'b0) vld_seen++;
        checks++;
        if (vld_seen != 0) begin
            failures++;
            $display("FAIL en_no_vld got %0d per_vld cycles want 0", vld_seen);
        end
        idle(2);
        send_edge();
        checks++;
        if ({per_vld8, period8, match8} !== {1'b1, 8'd6, 1'b1}) begin
            failures++;
            $display("FAIL en_resume got vld=%b per=%0d m=%b want vld=1 per=6 m=1",
                     per_vld8, period8, match8);
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        exp8 = 8'd2;
        send_edge();
        for (int i = 1; i <= 2; i++) begin
            idle(1);
            checks++;
            if (per_vld8 !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gap%0d got vld=%b want 0", i, per_vld8);
            end
            send_edge();
            checks++;
            if ({per_vld8, period8, match8} !== {1'b1, 8'd2, 1'b1}) begin
                failures++;
                $display("FAIL b2b_meas%0d got vld=%b per=%0d m=%b want vld=1 per=2 m=1",
                         i, per_vld8, period8, match8);
            end
        end
        exp8 = 8'd6;
    endtask

    task automatic test_async_reset();
        do_clr();
        send_edge();
        for (int i = 0; i < 4; i++) begin
            idle(5);
            send_edge();
        end
        checks++;
        if (locked8 !== 1'b1) begin
            failures++;
            $display("FAIL areset_prelock got l=%b want 1", locked8);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({period8, per_vld8, match8, locked8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL areset_immediate got per=%0d vld=%b m=%b l=%b o=%b want all 0",
                     period8, per_vld8, match8, locked8, ovf8);
        end
        #2 rst_b = 1'b1;
        step();
        send_edge();
        checks++;
        if ({per_vld8, period8} !== {1'b0, 8'd0}) begin
            failures++;
            $display("FAIL areset_arm got vld=%b per=%0d want vld=0 per=0", per_vld8, period8);
        end
        idle(5);
        send_edge();
        checks++;
        if ({per_vld8, period8, match8} !== {1'b1, 8'd6, 1'b1}) begin
            failures++;
            $display("FAIL areset_meas got vld=%b per=%0d m=%b want vld=1 per=6 m=1",
                     per_vld8, period8, match8);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lock();
        test_unlock();
        test_clr();
        test_ovf();
        test_enable();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
